// File: rtl/fp16_pkg.sv
// Shared fp16 definitions.
// Contents:
//   - binary16 field widths and exponent bias
//   - canonical encodings: +0, +inf and the quiet NaN
//   - accumulator FSM state encoding
//   - a leading-one finder used during normalisation
package fp16_pkg;

  localparam int          FP16_EXP_W    = 5;
  localparam int          FP16_MAN_W    = 10;
  localparam int          FP16_BIAS     = 15;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_e;

  // Position of the most significant set bit; 0 when no bit is set.
  function automatic logic [3:0] lead_one(input logic [14:0] v);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 0; i < 15; i++) begin
      pos = v[i] ? 4'(i) : pos;
    end
    return pos;
  endfunction

endpackage

// File: rtl/fp16_add_rne.sv
// Combinational IEEE-754 binary16 adder with round-to-nearest-even.
// Subnormal operands are flushed to signed zero. A subnormal result is
// flushed to +0. Any NaN operand gives the canonical quiet NaN.
// Ports:
//   a, b : fp16 operands {sign, exp[4:0], mant[9:0]}
//   sum  : rounded fp16 sum
module fp16_add_rne
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic               swap_s, eff_sub_s, round_up_s;
  logic [15:0]        big_s, small_s;
  logic [4:0]         diff_s;
  logic [29:0]        al_full_s;
  logic [13:0]        big_al_s, small_al_s, norm_s;
  logic [14:0]        raw_s;
  logic [3:0]         lead_s;
  logic signed [6:0]  exp_n_s, exp_r_s;
  logic [11:0]        man_r_s;
  logic [9:0]         frac_r_s;

  assign a_nan_s  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
  assign b_nan_s  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
  assign a_inf_s  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
  assign b_inf_s  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
  // Exponent zero covers both true zero and flushed subnormals.
  assign a_zero_s = (a[14:10] == 5'h00);
  assign b_zero_s = (b[14:10] == 5'h00);

  // Order by magnitude so the subtraction below never goes negative.
  assign swap_s    = (b[14:0] > a[14:0]);
  assign big_s     = swap_s ? b : a;
  assign small_s   = swap_s ? a : b;
  assign diff_s    = big_s[14:10] - small_s[14:10];
  assign eff_sub_s = big_s[15] ^ small_s[15];

  // Smaller significand is shifted in a 30-bit window. The top 14 bits
  // carry mantissa+G+R; every bit that falls below is OR-ed into sticky.
  assign al_full_s  = {1'b1, small_s[9:0], 19'h00000} >> diff_s;
  assign big_al_s   = {1'b1, big_s[9:0], 3'b000};
  assign small_al_s = {al_full_s[29:17], al_full_s[16] | (|al_full_s[15:0])};
  assign raw_s      = eff_sub_s ? ({1'b0, big_al_s} - {1'b0, small_al_s})
                                : ({1'b0, big_al_s} + {1'b0, small_al_s});
  assign lead_s     = lead_one(raw_s);

  // Normalise so the hidden one sits at bit 13, then round to nearest even
  always_comb begin
    exp_n_s = $signed({2'b00, big_s[14:10]}) + $signed({3'b000, lead_s}) - 7'sd13;
    if (lead_s == 4'd14) begin
      norm_s = {raw_s[14:2], raw_s[1] | raw_s[0]};
    end else begin
      norm_s = raw_s[13:0] << (4'd13 - lead_s);
    end
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    man_r_s    = {1'b0, norm_s[13:3]} + {11'h000, round_up_s};
    // A carry out of rounding leaves an all-zero fraction one binade up.
    if (man_r_s[11]) begin
      exp_r_s  = exp_n_s + 7'sd1;
      frac_r_s = man_r_s[10:1];
    end else begin
      exp_r_s  = exp_n_s;
      frac_r_s = man_r_s[9:0];
    end
  end

  // Special-case priority: NaN, infinities, zeros, then the rounded datapath
  always_comb begin
    sum = FP16_POS_ZERO;
    if (a_nan_s || b_nan_s) begin
      sum = FP16_QNAN;
    end else if (a_inf_s && b_inf_s) begin
      sum = (a[15] == b[15]) ? a : FP16_QNAN;
    end else if (a_inf_s) begin
      sum = a;
    end else if (b_inf_s) begin
      sum = b;
    end else if (a_zero_s && b_zero_s) begin
      sum = {a[15] & b[15], 15'h0000};
    end else if (a_zero_s) begin
      sum = b;
    end else if (b_zero_s) begin
      sum = a;
    end else if (raw_s == 15'h0000) begin
      sum = FP16_POS_ZERO;
    end else if (exp_r_s >= 7'sd31) begin
      sum = {big_s[15], FP16_POS_INF[14:0]};
    end else if (exp_r_s <= 7'sd0) begin
      sum = FP16_POS_ZERO;
    end else begin
      sum = {big_s[15], exp_r_s[4:0], frac_r_s};
    end
  end

endmodule

// File: rtl/fp16_acc_stream.sv
// Per-frame fp16 accumulator on a valid/ready stream.
// Each frame (terminated by s_last) is summed into one fp16 value. The
// sum is presented with the saturating element count on the m_* side.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   s_valid/s_ready       : input beat handshake
//   s_data, s_last        : fp16 operand, end-of-frame marker
//   m_valid/m_ready       : result handshake
//   m_data, m_count       : frame sum, number of beats in the frame
module fp16_acc_stream
  import fp16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic [CNT_W-1:0] m_count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  acc_state_e       state_r, state_s;
  logic [15:0]      acc_r, acc_s, add_a_s, sum_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             s_ready_r, m_valid_r, beat_s;

  assign beat_s  = s_valid & s_ready_r;
  // First beat of a frame is added to +0 so that -0 is canonicalised.
  assign add_a_s = (state_r == ACC) ? acc_r : FP16_POS_ZERO;

  fp16_add_rne u_add (
    .a   (add_a_s),
    .b   (s_data),
    .sum (sum_s)
  );

  // Next-state, accumulator and counter update
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (beat_s) begin
          acc_s   = sum_s;
          cnt_s   = CNT_ONE;
          state_s = s_last ? DONE : ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (beat_s) begin
          acc_s   = sum_s;
          cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
          state_s = s_last ? DONE : ACC;
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (m_ready) begin
          acc_s   = FP16_POS_ZERO;
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        acc_s   = FP16_POS_ZERO;
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // State, accumulator, counter and registered handshake flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= FP16_POS_ZERO;
      cnt_r     <= CNT_ZERO;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      s_ready_r <= (state_s != DONE);
      m_valid_r <= (state_s == DONE);
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = acc_r;
  assign m_count = cnt_r;

endmodule

// File: tb/tb_fp16_acc_stream.sv
// Directed self-checking bench for fp16_acc_stream. Expected frame results
// are queued when a frame is driven and compared on each output handshake.
module tb_fp16_acc_stream;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, s_last, m_valid, m_ready;
  logic [15:0] s_data, m_data, m_count;

  always #5 clk = ~clk;

  fp16_acc_stream #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] count;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beats_taken = 0;
  int   taken_mark = 0;
  logic beat_now = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record handshakes that will happen at the coming edge, then advance.
  task automatic step();
    res_t r;
    beat_now = s_valid && s_ready && rst_n;
    if (beat_now) beats_taken++;
    if (m_valid && m_ready && rst_n) begin
      check("sb_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("frame_data", {16'h0000, m_data}, {16'h0000, r.data});
        check("frame_count", {16'h0000, m_count}, {16'h0000, r.count});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2, input logic [15:0] ed, input logic [15:0] ec);
    logic [15:0] bs [3];
    int budget;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    exp_q.push_back(res_t'({ed, ec}));
    for (int i = 0; i < n; i++) begin
      s_valid  = 1'b1;
      s_data   = bs[i];
      s_last   = (i == n - 1);
      beat_now = 1'b0;
      budget   = 0;
      while (!beat_now && budget < 20) begin
        step();
        budget++;
      end
      check("beat_accept", {31'd0, beat_now}, 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      step();
      budget++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {16'h0000, m_data}, 32'd0);
    check("rst_m_count", {16'h0000, m_count}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_s_ready", {31'd0, s_ready}, 32'd1);

    // 5 - 3 + 7 = 9 with latency and one-cycle bubble
    m_ready = 1'b1;
    send_frame(3, 16'h4500, 16'hC200, 16'h4700, 16'h4880, 16'd3);
    check("lat_m_valid", {31'd0, m_valid}, 32'd1);
    check("bubble_s_ready", {31'd0, s_ready}, 32'd0);
    check("f1_m_data", {16'h0000, m_data}, 32'h4880);
    step();
    check("post_hs_s_ready", {31'd0, s_ready}, 32'd1);
    check("post_hs_m_valid", {31'd0, m_valid}, 32'd0);

    // Rounding, overflow, cancellation, NaN and inf-inf frames
    send_frame(2, 16'h6800, 16'h3C00, 16'h0000, 16'h6800, 16'd2);
    send_frame(2, 16'h6800, 16'h4200, 16'h0000, 16'h6802, 16'd2);
    send_frame(2, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 16'd2);
    send_frame(2, 16'h4500, 16'hC500, 16'h0000, 16'h0000, 16'd2);
    send_frame(3, 16'h3C00, 16'h7C01, 16'h3C00, 16'h7E00, 16'd3);
    send_frame(2, 16'h7C00, 16'hFC00, 16'h0000, 16'h7E00, 16'd2);
    drain();

    // Backpressure on a single-beat frame, next frame waiting on s_valid
    m_ready = 1'b0;
    send_frame(1, 16'hD800, 16'h0000, 16'h0000, 16'hD800, 16'd1);
    s_valid = 1'b1; s_data = 16'h8000; s_last = 1'b1;
    exp_q.push_back(res_t'({16'h0000, 16'd1}));
    taken_mark = beats_taken;
    for (int c = 0; c < 3; c++) begin
      check("bp_m_valid", {31'd0, m_valid}, 32'd1);
      check("bp_m_data", {16'h0000, m_data}, 32'hD800);
      check("bp_m_count", {16'h0000, m_count}, 32'd1);
      check("bp_s_ready", {31'd0, s_ready}, 32'd0);
      step();
    end
    check("bp_no_beat", beats_taken, taken_mark);
    m_ready = 1'b1;
    step();
    check("bp_release_s_ready", {31'd0, s_ready}, 32'd1);
    check("bp_release_m_valid", {31'd0, m_valid}, 32'd0);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    check("bp_next_beat", beats_taken, taken_mark + 1);
    check("neg_zero_m_valid", {31'd0, m_valid}, 32'd1);
    drain();

    // Reset after two beats of a frame discards it
    s_valid = 1'b1; s_data = 16'h4500; s_last = 1'b0;
    step();
    step();
    s_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_m_data", {16'h0000, m_data}, 32'd0);
    check("mid_rst_m_count", {16'h0000, m_count}, 32'd0);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    send_frame(2, 16'h3C00, 16'h3C00, 16'h0000, 16'h4000, 16'd2);
    drain();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
